// File: rtl/dec_ram_pkg.sv
// Shared constants and types for the two-bank LDPC decision-bit RAM.
// Used by dec_ram, dec_ram_bank and dec_ram_if.
package dec_ram_pkg;

  localparam int NUM_BANKS      = 2;
  localparam int DEF_DATA_WIDTH = 1;
  localparam int DEF_A_WIDTH    = 8;

  typedef logic bank_t;

endpackage

// File: rtl/dec_ram_if.sv
// Access bus of the decision-bit RAM: select, write and readback signals.
// Master drives the access, the RAM (slave) returns data_out.
interface dec_ram_if
  import dec_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int A_WIDTH    = DEF_A_WIDTH
);

  logic                  cs;
  logic                  we;
  bank_t                 rs;
  logic [A_WIDTH-1:0]    address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output cs, we, rs, address, data_in,
    input  data_out
  );

  modport slave (
    input  cs, we, rs, address, data_in,
    output data_out
  );

endinterface

// File: rtl/dec_ram_bank.sv
// One bank of decision bits: async-clear flop array, sync write, comb read.
// Writes only when the shared bus selects this bank.
module dec_ram_bank
  import dec_ram_pkg::*;
#(
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int    A_WIDTH    = DEF_A_WIDTH,
  parameter int    RAM_DEPTH  = 1 << A_WIDTH,
  parameter bank_t BANK_ID    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  bank_t                 rs,
  input  logic [A_WIDTH-1:0]    address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [RAM_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
  logic [RAM_DEPTH-1:0][DATA_WIDTH-1:0] mem_d;
  logic                                 wr_en;

  assign wr_en = cs & we & (rs == BANK_ID);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[address] = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[address];

endmodule

// File: rtl/dec_ram.sv
// Two-bank decision-bit RAM: write one codeword while reading the other.
// Macro DEC_RAM_WR_BYPASS_EN selects a write-first view of data_out.
module dec_ram
  import dec_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int RAM_DEPTH  = 1 << A_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  dec_ram_if.slave bus
);

  logic                  in_range;
  logic                  bank_cs;
  logic [DATA_WIDTH-1:0] rd [NUM_BANKS];
  logic [DATA_WIDTH-1:0] dout;

  assign in_range = {1'b0, bus.address} < (A_WIDTH + 1)'(RAM_DEPTH);
  assign bank_cs  = bus.cs & in_range;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    dec_ram_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .A_WIDTH    (A_WIDTH),
      .RAM_DEPTH  (RAM_DEPTH),
      .BANK_ID    (bank_t'(b))
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .cs      (bank_cs),
      .we      (bus.we),
      .rs      (bus.rs),
      .address (bus.address),
      .data_in (bus.data_in),
      .rd_data (rd[b])
    );
  end

  // Reset forces zero even on the bypass path.
  always_comb begin
    dout = '0;
    if (bank_cs && rst_n) begin
`ifdef DEC_RAM_WR_BYPASS_EN
      if (bus.we) begin
        dout = bus.data_in;
      end else begin
        dout = rd[bus.rs];
      end
`else
      dout = rd[bus.rs];
`endif
    end
  end

  assign bus.data_out = dout;

endmodule

// File: tb/tb_dec_ram.sv
// Scoreboard bench for dec_ram: stimulus queues expectations, a monitor
// compares data_out at each falling edge against a plain array model.
module tb_dec_ram;

  localparam int DW    = 1;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  dec_ram_if #(.DATA_WIDTH(DW), .A_WIDTH(AW)) bus ();

  dec_ram #(
    .DATA_WIDTH (DW),
    .A_WIDTH    (AW),
    .RAM_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    string         tag;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model [2][DEPTH];
  int            n_chk;
  int            n_fail;

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++)
        model[b][a] = '0;
  endtask

  // One access per cycle, driven just after the rising edge.
  task automatic op(input bit c, input bit w, input bit r,
                    input int a, input logic [DW-1:0] d,
                    input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    bus.cs      = c;
    bus.we      = w;
    bus.rs      = r;
    bus.address = AW'(a);
    bus.data_in = d;
    e.tag = tag;
    if (!rst_n || !c || a >= DEPTH) begin
      e.val = '0;
    end else if (w) begin
`ifdef DEC_RAM_WR_BYPASS_EN
      e.val = d;
`else
      e.val = model[r][a];
`endif
    end else begin
      e.val = model[r][a];
    end
    sb.push_back(e);
    if (rst_n && c && w && a < DEPTH)
      model[r][a] = d;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if (bus.data_out !== e.val) begin
        n_fail++;
        $display("FAIL %s: rs=%0d addr=%0d data_out=%0h expected %0h t=%0t",
                 e.tag, bus.rs, bus.address, bus.data_out, e.val, $time);
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clear_model();
    rst_n       = 1'b0;
    bus.cs      = 1'b0;
    bus.we      = 1'b0;
    bus.rs      = 1'b0;
    bus.address = '0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset clears stored data asynchronously and beats a write
    op(1, 1, 0, 5, 1'b1, "rst_pre_wr");
    op(1, 0, 0, 5, 1'b0, "rst_pre_rd");
    @(posedge clk);
    #3 rst_n = 1'b0;
    clear_model();
    op(1, 1, 0, 5, 1'b1, "rst_hold_wr");
    op(1, 0, 0, 5, 1'b0, "rst_hold_rd");
    @(posedge clk);
    #1 rst_n = 1'b1;
    op(1, 0, 0, 5, 1'b0, "rst_addr5");
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++)
        op(1, 0, b[0], a, 1'b0, "rst_all");

    // fill and read back each bank
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < DEPTH; a++)
        op(1, 1, b[0], a, DW'($urandom_range(1)), "fill_wr");
      for (int a = 0; a < DEPTH; a++)
        op(1, 0, b[0], a, 1'b0, "fill_rd");
    end
    for (int a = 0; a < DEPTH; a++)
      op(1, 0, 0, a, 1'b0, "bank0_kept");

    // same address, different banks
    op(1, 1, 0, 10, 1'b1, "iso_wr0");
    op(1, 1, 1, 10, 1'b0, "iso_wr1");
    op(1, 0, 0, 10, 1'b0, "iso_rd0");
    op(1, 0, 1, 10, 1'b0, "iso_rd1");

    // chip select low: no write, output zero
    op(1, 1, 0, 3, 1'b0, "cs_prep");
    op(0, 1, 0, 3, 1'b1, "cs_low");
    op(0, 0, 0, 3, 1'b0, "cs_low_rd");
    op(1, 0, 0, 3, 1'b0, "cs_back");

    // read during write, then read after the edge
    op(1, 1, 0, 7, 1'b0, "rdw_prep");
    op(1, 1, 0, 7, 1'b1, "rdw_during");
    op(1, 0, 0, 7, 1'b0, "rdw_after");

    // back-to-back writes, last wins
    op(1, 1, 1, 20, 1'b1, "b2b_wr1");
    op(1, 1, 1, 20, 1'b0, "b2b_wr2");
    op(1, 0, 1, 20, 1'b0, "b2b_rd");

    // random mixed traffic
    for (int i = 0; i < 400; i++)
      op($urandom_range(3) != 0, $urandom_range(1) != 0,
         $urandom_range(1) != 0, $urandom_range(DEPTH - 1),
         DW'($urandom_range(1)), "random");

    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_ram.md
# dec_ram

Two-bank, single-port decision-bit RAM for the LDPC decoder. It stores hard-decision bits per variable node and sits between the decoder core and the output/readback logic. Input `rs` selects one of two banks, so one codeword's decisions can be written while the previous codeword's decisions are read out. Writes are synchronous and reads are combinational.

## Interface
- `DATA_WIDTH`, default 1: word width in bits.
- `A_WIDTH`, default 8: address width.
- `RAM_DEPTH`, default `1<<A_WIDTH`: words per bank. Must satisfy `RAM_DEPTH` ≤ 2^`A_WIDTH`.

Ports:
- `clk`, input, 1 bit: single clock; all writes occur on its rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `cs`, input, 1 bit: chip select; the RAM is inert when low.
- `we`, input, 1 bit: write enable; high means write, low means read.
- `rs`, input, 1 bit: bank (region) select; 0 selects bank 0, 1 selects bank 1.
- `address`, input, `A_WIDTH` bits: word address within the selected bank.
- `data_in`, input, `DATA_WIDTH` bits: write data.
- `data_out`, output, `DATA_WIDTH` bits: read data.

## Operation
- Storage is 2 × `RAM_DEPTH` words of `DATA_WIDTH` bits, held in flops so it is resettable.
- **Write:** on a rising `clk` with `cs`=1 and `we`=1, store `mem[rs][address]` ← `data_in`. The other bank is untouched.
- **Read:** `data_out` = `mem[rs][address]` combinationally whenever `cs`=1. This includes cycles with `we`=1, where the stored (pre-edge) value is shown unless the bypass feature is compiled in.
- `cs`=0: no write occurs and `data_out` = 0.
- `address` ≥ `RAM_DEPTH`: the write is ignored and `data_out` = 0.
- Banks are fully independent. The same address in bank 0 and bank 1 holds distinct words.
- **Reset:** while `rst_n`=0, every word of both banks is 0, so `data_out` = 0. Reset wins over a simultaneous write. Asserting reset mid-operation clears all contents immediately, without waiting for a clock edge.

## Timing
- Write latency: the new data is visible on `data_out` immediately after the capturing rising edge, provided `rs`/`address` are unchanged. A read in the next cycle returns it.
- Read latency: 0 cycles, combinational from `rs`, `address`, `cs` (and `we` when bypass is enabled).
- No handshake is needed; one access may occur every cycle.
- Back-to-back writes to the same address: the last write wins.
- Reset release: the first write can occur on the first rising edge at which `rst_n`=1 has been stable for setup.

## Configuration
- Macro `DEC_RAM_WR_BYPASS_EN`.
- **Defined:** when `cs`=1 and `we`=1, `data_out` = `data_in` combinationally (write-first view).
- **Undefined:** during a write, `data_out` shows the currently stored `mem[rs][address]` (read-old).
- Storage behaviour is identical in both builds.

## Structure
- Package `dec_ram_pkg` holds:
  - `NUM_BANKS` = 2;
  - default `DATA_WIDTH`/`A_WIDTH` constants;
  - a bank-index typedef (1 bit).
- Sub-module `dec_ram_bank`, instantiated twice:
  - one `RAM_DEPTH` × `DATA_WIDTH` array with async-clear, synchronous write and combinational read;
  - write enable gated by `cs & we & (rs == bank_id)`.
- The top level handles:
  - output muxing on `rs`;
  - the address range check;
  - the `cs` gating;
  - the bypass path.

## Test plan
- **Reset:** `rst_n`=0 after writing 1 to bank 0 addr 5. Then `rst_n`=1 and read bank 0 addr 5 → `data_out`=0. Every address in both banks reads 0.
- **Bank 0 fill/readback:** `rs`=0, write 256 random bits to addresses 0..255, then read 0..255 → each equals the written bit.
- **Bank 1 fill/readback:** repeat the previous scenario with `rs`=1. Then read bank 0 → still holds its earlier data, proving bank isolation.
- **Same-address isolation:** write 1 to addr 10 in bank 0 and 0 to addr 10 in bank 1 → reads return 1 and 0 respectively.
- **Chip select:** with `cs`=0, `we`=1, `data_in`=1 at addr 3 → no write (addr 3 still reads 0 after `cs`=1), and `data_out`=0 while `cs`=0.
- **Read during write:** write 1 over a stored 0 at addr 7 → before the edge, `data_out`=0 without the macro and 1 with `DEC_RAM_WR_BYPASS_EN`. After the edge it is 1 in both builds.
